// File: rtl/ro_buffer_pkg.sv
// Shared types for the in-order reorder buffer: issue signal kinds, entry layout and default geometry.
package ro_buffer_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_TAG_W = 5;

   typedef enum logic [1:0] {
      ISSUER_TO_ROB_SIGNAL_NORMAL = 2'd0,
      ISSUER_TO_ROB_SIGNAL_LOAD   = 2'd1,
      ISSUER_TO_ROB_SIGNAL_STORE  = 2'd2,
      ISSUER_TO_ROB_SIGNAL_BRANCH = 2'd3
   } issuer_sig_e;

   typedef struct packed {
      logic        busy;
      logic        ready;
      issuer_sig_e sig;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic [31:0] value;
      logic [31:0] alu_next_pc;
   } rob_entry_t;

endpackage

// File: rtl/ro_buffer_operand_port.sv
// Combinational tag -> (valid, value) operand lookup into the ROB, with optional same-cycle CDB bypass.
// Zero latency; no backpressure (pure lookup).
module rob_operand_port
   import ro_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = ROB_TAG_W
) (
   input  logic [TAG_W-1:0]        q,
   input  logic [DEPTH-1:0]        ready_vec,
   input  logic [DEPTH-1:0][31:0]  value_vec,
   input  logic                    alu_valid,
   input  logic [TAG_W-1:0]        alu_dest,
   input  logic [31:0]             alu_value,
   input  logic                    lsb_valid,
   input  logic [TAG_W-1:0]        lsb_dest,
   input  logic [31:0]             lsb_value,
   output logic                    valid,
   output logic [31:0]             value
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [IDX_W-1:0] idx;

   assign idx = IDX_W'(q - TAG_W'(1));

`ifdef ROB_CDB_BYPASS_EN
   always_comb begin
      valid = 1'b0;
      value = value_vec[idx];
      if (q != '0) begin
         valid = ready_vec[idx];
         // A result broadcast this cycle beats the registered copy; ALU has priority over LSB.
         if (alu_valid && alu_dest == q) begin
            valid = 1'b1;
            value = alu_value;
         end else if (lsb_valid && lsb_dest == q) begin
            valid = 1'b1;
            value = lsb_value;
         end
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{alu_valid, alu_dest, alu_value, lsb_valid, lsb_dest, lsb_value};

   always_comb begin
      valid = 1'b0;
      value = value_vec[idx];
      if (q != '0) begin
         valid = ready_vec[idx];
      end
   end
`endif

endmodule

// File: rtl/ro_buffer.sv
// In-order reorder buffer: tag allocation, CDB capture, operand lookup, in-order retire and mispredict flush.
// Commit/flush outputs are registered one-cycle pulses; issuer is throttled by is_full (one issue in flight); ROB_CDB_BYPASS_EN adds lookup bypass.
module ro_buffer
   import ro_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = ROB_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             valid_from_issuer,
   input  logic [1:0]       signal_from_issuer,
   input  logic [4:0]       rd_from_issuer,
   input  logic [31:0]      pc_from_issuer,
   input  logic [31:0]      next_pc_from_issuer,
   output logic [TAG_W-1:0] dest_to_issuer,
   output logic             is_full_to_issuer,
   input  logic [TAG_W-1:0] qj_from_issuer,
   input  logic [TAG_W-1:0] qk_from_issuer,
   output logic             valid_of_vj_to_issuer,
   output logic             valid_of_vk_to_issuer,
   output logic [31:0]      vj_to_issuer,
   output logic [31:0]      vk_to_issuer,
   input  logic             alu_valid,
   input  logic [TAG_W-1:0] alu_dest,
   input  logic [31:0]      alu_value,
   input  logic [31:0]      alu_next_pc,
   input  logic             lsb_valid,
   input  logic [TAG_W-1:0] lsb_dest,
   input  logic [31:0]      lsb_value,
   output logic             commit_valid_to_reg_file,
   output logic [4:0]       rd_to_reg_file,
   output logic [TAG_W-1:0] dest_to_reg_file,
   output logic [31:0]      value_to_reg_file,
   output logic             store_commit_to_ls_buffer,
   output logic [TAG_W-1:0] dest_of_store,
   output logic             reset_to_rob_bus,
   output logic [31:0]      pc_to_inst_fetcher
);
   localparam int IDX_W = $clog2(DEPTH);

   rob_entry_t             entries [DEPTH];
   logic [IDX_W-1:0]       head, tail, dest_idx, alu_idx, lsb_idx;
   logic [IDX_W:0]         count;
   logic [IDX_W+1:0]       fill_next;
   logic [TAG_W-1:0]       head_tag;
   logic                   issue_en, do_commit, mispredict, alu_hit, lsb_hit;
   logic [DEPTH-1:0]       ready_vec;
   logic [DEPTH-1:0][31:0] value_vec;

   // The issuer ignores its own strobe during a flush cycle, so the allocation view must too.
   assign issue_en          = valid_from_issuer && !reset_to_rob_bus;
   assign dest_idx          = tail + IDX_W'(issue_en);
   assign dest_to_issuer    = TAG_W'(dest_idx) + TAG_W'(1);
   assign fill_next         = (IDX_W+2)'(count) + (IDX_W+2)'(issue_en);
   assign is_full_to_issuer = fill_next >= (IDX_W+2)'(DEPTH-1);

   assign alu_idx  = IDX_W'(alu_dest - TAG_W'(1));
   assign lsb_idx  = IDX_W'(lsb_dest - TAG_W'(1));
   assign alu_hit  = alu_valid && alu_dest != '0 && alu_dest <= TAG_W'(DEPTH) && entries[alu_idx].busy;
   assign lsb_hit  = lsb_valid && lsb_dest != '0 && lsb_dest <= TAG_W'(DEPTH) && entries[lsb_idx].busy;
   assign head_tag = TAG_W'(head) + TAG_W'(1);

   assign do_commit  = entries[head].busy && entries[head].ready;
   assign mispredict = do_commit && entries[head].sig == ISSUER_TO_ROB_SIGNAL_BRANCH &&
                       entries[head].alu_next_pc != entries[head].next_pc;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = entries[i].ready;
         value_vec[i] = entries[i].value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head                      <= '0;
         tail                      <= '0;
         count                     <= '0;
         commit_valid_to_reg_file  <= 1'b0;
         rd_to_reg_file            <= '0;
         dest_to_reg_file          <= '0;
         value_to_reg_file         <= '0;
         store_commit_to_ls_buffer <= 1'b0;
         dest_of_store             <= '0;
         reset_to_rob_bus          <= 1'b0;
         pc_to_inst_fetcher        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].busy  <= 1'b0;
            entries[i].ready <= 1'b0;
         end
      end else if (rdy) begin
         commit_valid_to_reg_file  <= 1'b0;
         rd_to_reg_file            <= '0;
         dest_to_reg_file          <= '0;
         value_to_reg_file         <= '0;
         store_commit_to_ls_buffer <= 1'b0;
         dest_of_store             <= '0;
         reset_to_rob_bus          <= 1'b0;
         pc_to_inst_fetcher        <= '0;
         if (do_commit) begin
            if (entries[head].sig == ISSUER_TO_ROB_SIGNAL_STORE) begin
               store_commit_to_ls_buffer <= 1'b1;
               dest_of_store             <= head_tag;
            end else begin
               commit_valid_to_reg_file <= 1'b1;
               rd_to_reg_file           <= entries[head].rd;
               dest_to_reg_file         <= head_tag;
               value_to_reg_file        <= entries[head].value;
            end
         end
         if (mispredict) begin
            // The branch itself still retires (link write above); everything younger is squashed.
            reset_to_rob_bus   <= 1'b1;
            pc_to_inst_fetcher <= entries[head].alu_next_pc;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               entries[i].busy  <= 1'b0;
               entries[i].ready <= 1'b0;
            end
         end else begin
            if (alu_hit) begin
               entries[alu_idx].value       <= alu_value;
               entries[alu_idx].alu_next_pc <= alu_next_pc;
               entries[alu_idx].ready       <= 1'b1;
            end
            if (lsb_hit) begin
               entries[lsb_idx].value <= lsb_value;
               entries[lsb_idx].ready <= 1'b1;
            end
            if (do_commit) begin
               entries[head].busy  <= 1'b0;
               entries[head].ready <= 1'b0;
               head                <= head + IDX_W'(1);
            end
            if (issue_en) begin
               entries[tail] <= '{busy: 1'b1, ready: 1'b0, sig: issuer_sig_e'(signal_from_issuer),
                                  rd: rd_from_issuer, pc: pc_from_issuer, next_pc: next_pc_from_issuer,
                                  value: '0, alu_next_pc: '0};
               tail          <= tail + IDX_W'(1);
            end
            count <= count + (IDX_W+1)'(issue_en) - (IDX_W+1)'(do_commit);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && issue_en) begin
         assert (count != (IDX_W+1)'(DEPTH)) else $error("ro_buffer: issue strobe while full");
      end
   end

   rob_operand_port #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_port_j (
      .q(qj_from_issuer), .ready_vec(ready_vec), .value_vec(value_vec),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_value(alu_value),
      .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
      .valid(valid_of_vj_to_issuer), .value(vj_to_issuer)
   );

   rob_operand_port #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_port_k (
      .q(qk_from_issuer), .ready_vec(ready_vec), .value_vec(value_vec),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_value(alu_value),
      .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
      .valid(valid_of_vk_to_issuer), .value(vk_to_issuer)
   );

endmodule

// File: tb/tb_ro_buffer.sv
// Directed scenarios then randomized traffic for ro_buffer, checked against a queue-based ROB model.
module tb_ro_buffer;
   localparam int DEPTH = 16;
`ifdef ROB_CDB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif
   localparam logic [1:0] S_NORMAL = 2'd0, S_LOAD = 2'd1, S_STORE = 2'd2, S_BRANCH = 2'd3;

   logic        clk, rst, rdy;
   logic        valid_from_issuer;
   logic [1:0]  signal_from_issuer;
   logic [4:0]  rd_from_issuer;
   logic [31:0] pc_from_issuer, next_pc_from_issuer;
   logic [4:0]  dest_to_issuer;
   logic        is_full_to_issuer;
   logic [4:0]  qj_from_issuer, qk_from_issuer;
   logic        valid_of_vj_to_issuer, valid_of_vk_to_issuer;
   logic [31:0] vj_to_issuer, vk_to_issuer;
   logic        alu_valid, lsb_valid;
   logic [4:0]  alu_dest, lsb_dest;
   logic [31:0] alu_value, alu_next_pc, lsb_value;
   logic        commit_valid_to_reg_file, store_commit_to_ls_buffer, reset_to_rob_bus;
   logic [4:0]  rd_to_reg_file, dest_to_reg_file, dest_of_store;
   logic [31:0] value_to_reg_file, pc_to_inst_fetcher;

   ro_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .valid_from_issuer(valid_from_issuer), .signal_from_issuer(signal_from_issuer),
      .rd_from_issuer(rd_from_issuer), .pc_from_issuer(pc_from_issuer),
      .next_pc_from_issuer(next_pc_from_issuer),
      .dest_to_issuer(dest_to_issuer), .is_full_to_issuer(is_full_to_issuer),
      .qj_from_issuer(qj_from_issuer), .qk_from_issuer(qk_from_issuer),
      .valid_of_vj_to_issuer(valid_of_vj_to_issuer), .valid_of_vk_to_issuer(valid_of_vk_to_issuer),
      .vj_to_issuer(vj_to_issuer), .vk_to_issuer(vk_to_issuer),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_value(alu_value), .alu_next_pc(alu_next_pc),
      .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
      .commit_valid_to_reg_file(commit_valid_to_reg_file), .rd_to_reg_file(rd_to_reg_file),
      .dest_to_reg_file(dest_to_reg_file), .value_to_reg_file(value_to_reg_file),
      .store_commit_to_ls_buffer(store_commit_to_ls_buffer), .dest_of_store(dest_of_store),
      .reset_to_rob_bus(reset_to_rob_bus), .pc_to_inst_fetcher(pc_to_inst_fetcher)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      logic [1:0]  sig;
      logic [4:0]  rd;
      logic [31:0] npc;
      bit          done;
      logic [31:0] val;
      logic [31:0] anpc;
   } ment_t;

   ment_t       mq[$];
   int          m_tail;
   bit          m_flush;
   logic        e_cv, e_sc, e_rb;
   logic [4:0]  e_rd, e_dest, e_dos;
   logic [31:0] e_val, e_pc;
   int          errors, checks;
   logic [4:0]  obs_dest;
   logic        obs_full, obs_vjv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int nt(input int t);
      return (t == DEPTH) ? 1 : t + 1;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_tail = 1; m_flush = 0;
      e_cv = 0; e_sc = 0; e_rb = 0; e_rd = 0; e_dest = 0; e_dos = 0; e_val = 0; e_pc = 0;
   endfunction

   function automatic void mlook(input logic [4:0] q, output logic v, output logic [31:0] val);
      v = 1'b0; val = '0;
      if (q == 0) return;
      foreach (mq[i]) if (mq[i].tag == int'(q) && mq[i].done) begin v = 1'b1; val = mq[i].val; end
      if (BYP && alu_valid && alu_dest == q) begin v = 1'b1; val = alu_value; end
      else if (BYP && lsb_valid && lsb_dest == q) begin v = 1'b1; val = lsb_value; end
   endfunction

   task automatic idle();
      rst = 0; rdy = 1; valid_from_issuer = 0; signal_from_issuer = 0; rd_from_issuer = 0;
      pc_from_issuer = 0; next_pc_from_issuer = 0; qj_from_issuer = 0; qk_from_issuer = 0;
      alu_valid = 0; alu_dest = 0; alu_value = 0; alu_next_pc = 0;
      lsb_valid = 0; lsb_dest = 0; lsb_value = 0;
   endtask

   task automatic set_issue(input logic [1:0] s, input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] npc);
      valid_from_issuer = 1; signal_from_issuer = s; rd_from_issuer = rd;
      pc_from_issuer = pc; next_pc_from_issuer = npc;
   endtask

   task automatic set_alu(input logic [4:0] t, input logic [31:0] v, input logic [31:0] npc);
      alu_valid = 1; alu_dest = t; alu_value = v; alu_next_pc = npc;
   endtask

   // One clock: comb outputs checked mid-cycle, model advanced, registered outputs checked after the edge.
   task automatic step();
      logic veff, ev;
      logic [31:0] evv;
      ment_t h;
      bit cm, mis;
      @(negedge clk);
      veff = valid_from_issuer && !m_flush;
      obs_dest = dest_to_issuer; obs_full = is_full_to_issuer; obs_vjv = valid_of_vj_to_issuer;
      chk("dest_to_issuer", dest_to_issuer, veff ? nt(m_tail) : m_tail);
      chk("is_full", is_full_to_issuer, (mq.size() + int'(veff)) >= DEPTH - 1);
      mlook(qj_from_issuer, ev, evv);
      chk("vj_valid", valid_of_vj_to_issuer, ev);
      if (ev) chk("vj_value", vj_to_issuer, evv);
      mlook(qk_from_issuer, ev, evv);
      chk("vk_valid", valid_of_vk_to_issuer, ev);
      if (ev) chk("vk_value", vk_to_issuer, evv);
      if (rst) model_reset();
      else if (rdy) begin
         e_cv = 0; e_sc = 0; e_rb = 0; e_rd = 0; e_dest = 0; e_dos = 0; e_val = 0; e_pc = 0;
         cm = mq.size() > 0 && mq[0].done;
         mis = 0;
         if (cm) begin
            h = mq[0];
            if (h.sig == S_STORE) begin e_sc = 1; e_dos = 5'(h.tag); end
            else begin e_cv = 1; e_rd = h.rd; e_dest = 5'(h.tag); e_val = h.val; end
            mis = (h.sig == S_BRANCH) && (h.anpc != h.npc);
         end
         if (mis) begin
            mq.delete(); m_tail = 1; e_rb = 1; e_pc = h.anpc;
         end else begin
            foreach (mq[i]) begin
               if (alu_valid && mq[i].tag == int'(alu_dest)) begin
                  mq[i].done = 1; mq[i].val = alu_value; mq[i].anpc = alu_next_pc;
               end
               if (lsb_valid && mq[i].tag == int'(lsb_dest)) begin
                  mq[i].done = 1; mq[i].val = lsb_value;
               end
            end
            if (cm) void'(mq.pop_front());
            if (veff) begin
               mq.push_back('{tag: m_tail, sig: signal_from_issuer, rd: rd_from_issuer,
                              npc: next_pc_from_issuer, done: 0, val: 0, anpc: 0});
               m_tail = nt(m_tail);
            end
         end
         m_flush = e_rb;
      end
      @(posedge clk); #1;
      chk("commit_valid", commit_valid_to_reg_file, e_cv);
      chk("rd_to_reg_file", rd_to_reg_file, e_rd);
      chk("dest_to_reg_file", dest_to_reg_file, e_dest);
      chk("value_to_reg_file", value_to_reg_file, e_val);
      chk("store_commit", store_commit_to_ls_buffer, e_sc);
      chk("dest_of_store", dest_of_store, e_dos);
      chk("reset_to_rob_bus", reset_to_rob_bus, e_rb);
      chk("pc_to_inst_fetcher", pc_to_inst_fetcher, e_pc);
   endtask

   initial begin
      int cand[$];
      int k;
      bit seen;
      logic [4:0] seen_dos;
      logic seen_cv;
      errors = 0; checks = 0;
      idle(); rst = 1;
      repeat (2) @(posedge clk);
      #1; model_reset();

      // In-order retire despite out-of-order results
      rst = 1; step(); idle();
      step(); chk("d1_dest_first", obs_dest, 1);
      set_issue(S_NORMAL, 5'd1, 32'h10, 32'h14); step(); chk("d1_dest_a", obs_dest, 2);
      step(); chk("d1_dest_b", obs_dest, 3);
      step(); chk("d1_dest_c", obs_dest, 4);
      idle(); set_alu(5'd2, 32'h22, 32'h0); step();
      idle(); set_alu(5'd1, 32'h11, 32'h0); step();
      idle(); step();
      chk("d1_c1_valid", commit_valid_to_reg_file, 1);
      chk("d1_c1_dest", dest_to_reg_file, 1);
      chk("d1_c1_value", value_to_reg_file, 32'h11);
      step();
      chk("d1_c2_dest", dest_to_reg_file, 2);
      chk("d1_c2_value", value_to_reg_file, 32'h22);

      // Full threshold and tail wrap
      idle(); rst = 1; step(); idle();
      for (int i = 0; i < DEPTH - 1; i++) begin set_issue(S_NORMAL, 5'(i), 32'h0, 32'h4); step(); end
      chk("d2_full_inflight", obs_full, 1);
      idle(); step(); chk("d2_full_hold", obs_full, 1);
      set_alu(5'd1, 32'h5, 32'h0); step();
      idle(); step();
      step(); chk("d2_full_drop", obs_full, 0);
      chk("d2_dest_tail", obs_dest, 16);
      set_issue(S_NORMAL, 5'd3, 32'h0, 32'h4); step(); chk("d2_wrap", obs_dest, 1);

      // Branch mispredict flush
      idle(); rst = 1; step(); idle();
      set_issue(S_BRANCH, 5'd1, 32'h100, 32'h104); step();
      idle(); set_alu(5'd1, 32'h104, 32'h200); step();
      idle(); step();
      chk("d3_flush", reset_to_rob_bus, 1);
      chk("d3_redirect", pc_to_inst_fetcher, 32'h200);
      chk("d3_link", commit_valid_to_reg_file, 1);
      set_issue(S_NORMAL, 5'd2, 32'h200, 32'h204); step();
      chk("d3_dest_after", obs_dest, 1);
      chk("d3_flush_end", reset_to_rob_bus, 0);
      idle(); step(); chk("d3_dest_empty", obs_dest, 1);

      // Store release; ALU and LSB in one cycle
      idle(); rst = 1; step(); idle();
      for (int i = 0; i < 3; i++) begin set_issue(S_NORMAL, 5'(i + 1), 32'h0, 32'h4); step(); end
      set_issue(S_STORE, 5'd0, 32'h0, 32'h4); step();
      idle(); set_alu(5'd1, 32'h1, 32'h0); step();
      idle(); set_alu(5'd2, 32'h2, 32'h0); step();
      idle(); set_alu(5'd3, 32'h3, 32'h0); lsb_valid = 1; lsb_dest = 5'd4; lsb_value = 32'h0; step();
      idle();
      seen = 0; seen_dos = 0; seen_cv = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (!seen && store_commit_to_ls_buffer) begin
            seen = 1; seen_dos = dest_of_store; seen_cv = commit_valid_to_reg_file;
         end
      end
      chk("d4_store_seen", seen, 1);
      chk("d4_store_tag", seen_dos, 4);
      chk("d4_no_regwrite", seen_cv, 0);

      // Lookup during a same-cycle broadcast
      idle(); rst = 1; step(); idle();
      for (int i = 0; i < 3; i++) begin set_issue(S_LOAD, 5'(i + 1), 32'h0, 32'h4); step(); end
      idle(); step();
      set_alu(5'd3, 32'hDEAD, 32'h0); qj_from_issuer = 5'd3; qk_from_issuer = 5'd2; step();
      chk("d5_bypass", obs_vjv, BYP);

      // Reset mid-stream with a ready head
      idle(); rst = 1; step(); idle();
      for (int i = 0; i < 5; i++) begin set_issue(S_NORMAL, 5'(i + 1), 32'h0, 32'h4); step(); end
      idle(); set_alu(5'd1, 32'h77, 32'h0); step();
      idle(); rst = 1; step(); idle();
      chk("d6_rst_cv", commit_valid_to_reg_file, 0);
      chk("d6_rst_rb", reset_to_rob_bus, 0);
      for (int i = 0; i < 3; i++) begin step(); chk("d6_no_commit", commit_valid_to_reg_file, 0); end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         rdy = ($urandom_range(0, 9) != 0);
         if (mq.size() < DEPTH && $urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, 7);
            set_issue((k == 0) ? S_BRANCH : (k == 1) ? S_STORE : (k == 2) ? S_LOAD : S_NORMAL,
                      5'($urandom), $urandom, $urandom);
         end
         cand = {};
         foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, cand.size() - 1);
            set_alu(5'(mq[cand[k]].tag), $urandom,
                    (mq[cand[k]].sig == S_BRANCH && $urandom_range(0, 3) != 0) ? mq[cand[k]].npc : $urandom);
            cand.delete(k);
         end else if ($urandom_range(0, 7) == 0) begin
            set_alu(($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(17, 31)), $urandom, $urandom);
         end
         if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, cand.size() - 1);
            lsb_valid = 1; lsb_dest = 5'(mq[cand[k]].tag); lsb_value = $urandom;
         end
         qj_from_issuer = 5'($urandom_range(0, DEPTH));
         qk_from_issuer = 5'($urandom_range(0, DEPTH));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
